// File: rtl/i2s_rx_mod.sv
// i2s_rx_mod: Philips I2S slave receiver, oversampled in the ctl_clk domain.
// BCLK, LRCK and data are synchronized, BCLK rising edges are detected, and
// each left/right slot is deserialized MSB first into a left-justified word.
// A completed stereo pair is presented with a one-cycle wave_valid strobe.
// Optional feature: define I2S_RX_SLOT_CHECK_EN to enable the sticky
// slot-length check on frame_err (otherwise frame_err is tied low).
module i2s_rx_mod #(
    parameter int BITWIDTH  = 24,
    parameter int SLOT_BITS = 32
) (
    input  logic                ctl_clk,
    input  logic                ctl_rst,
    input  logic                i2s_bclk,
    input  logic                i2s_lrck,
    input  logic                i2s_rx,
    output logic [BITWIDTH-1:0] wave_out_l,
    output logic [BITWIDTH-1:0] wave_out_r,
    output logic                wave_valid,
    output logic                frame_err
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    localparam logic [6:0] BW7 = 7'(BITWIDTH);

    state_t              state;
    logic [2:0]          bclk_s;
    logic [1:0]          lrck_s;
    logic [1:0]          rx_s;
    logic                lrck_prev;
    logic [5:0]          idx;
    logic [BITWIDTH-1:0] shreg;
    logic [BITWIDTH-1:0] hold_l;

    logic                bclk_rise;
    logic                lrck_d;
    logic                rx_d;
    logic                lrck_change;
    logic                idx_in_word;
    logic [6:0]          fill;
    logic [BITWIDTH-1:0] shift_in;
    logic [BITWIDTH-1:0] word;

    assign bclk_rise   = bclk_s[1] & ~bclk_s[2];
    assign lrck_d      = lrck_s[1];
    assign rx_d        = rx_s[1];
    assign lrck_change = (lrck_d != lrck_prev);
    assign fill        = {1'b0, idx} + 7'd1;
    assign idx_in_word = ({1'b0, idx} < BW7);

    // Shift register contents including the current bit (only while inside the word)
    assign shift_in = idx_in_word ? ((shreg << 1) | BITWIDTH'(rx_d)) : shreg;

    // Short slots are left-justified so the MSB of the slot lands in the word MSB
    assign word = (fill < BW7) ? (shift_in << (BW7 - fill)) : shift_in;

    // Two-stage synchronizers for all pins, plus a third BCLK stage for edge detection
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            bclk_s <= 3'b000;
            lrck_s <= 2'b00;
            rx_s   <= 2'b00;
        end else begin
            bclk_s <= {bclk_s[1:0], i2s_bclk};
            lrck_s <= {lrck_s[0], i2s_lrck};
            rx_s   <= {rx_s[0], i2s_rx};
        end
    end

    // Slot deserializer and frame state machine, advanced once per BCLK rising edge
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            state      <= SYNC;
            idx        <= 6'd0;
            shreg      <= '0;
            hold_l     <= '0;
            lrck_prev  <= 1'b0;
            wave_out_l <= '0;
            wave_out_r <= '0;
            wave_valid <= 1'b0;
        end else begin
            wave_valid <= 1'b0;
            if (bclk_rise) begin
                lrck_prev <= lrck_d;
                if (lrck_change) begin
                    idx   <= 6'd0;
                    shreg <= '0;
                    case (state)
                        SYNC: begin
                            if (!lrck_d) begin
                                state <= LEFT;
                            end
                        end
                        LEFT: begin
                            if (lrck_d) begin
                                hold_l <= word;
                                state  <= RIGHT;
                            end
                        end
                        RIGHT: begin
                            if (!lrck_d) begin
                                wave_out_l <= hold_l;
                                wave_out_r <= word;
                                wave_valid <= 1'b1;
                                state      <= LEFT;
                            end
                        end
                        default: state <= SYNC;
                    endcase
                end else begin
                    if (idx_in_word) begin
                        shreg <= shift_in;
                    end
                    if (idx != 6'd63) begin
                        idx <= idx + 6'd1;
                    end
                end
            end
        end
    end

`ifdef I2S_RX_SLOT_CHECK_EN
    localparam logic [6:0] SLOT7 = 7'(SLOT_BITS);

    // Sticky flag set when a slot closed outside SYNC had the wrong bit count
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            frame_err <= 1'b0;
        end else if (bclk_rise && lrck_change && (state != SYNC) && (fill != SLOT7)) begin
            frame_err <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_mod.sv
// tb_i2s_rx_mod: directed-vector bench for i2s_rx_mod with a scoreboard.
// Stimulus pushes expected {left,right} pairs into a queue; a monitor pops
// and compares whenever wave_valid pulses.
`timescale 1ns/1ps
module tb_i2s_rx_mod;

    localparam int BW = 24;
`ifdef I2S_RX_SLOT_CHECK_EN
    localparam int SLOT_CHECK = 1;
`else
    localparam int SLOT_CHECK = 0;
`endif

    logic          ctl_clk;
    logic          ctl_rst;
    logic          i2s_bclk;
    logic          i2s_lrck;
    logic          i2s_rx;
    logic [BW-1:0] wave_out_l;
    logic [BW-1:0] wave_out_r;
    logic          wave_valid;
    logic          frame_err;

    int            checks;
    int            errors;
    int            half;
    logic          pending;
    logic          prev_valid;
    logic [47:0]   exp_q[$];

    logic [23:0]   ramp_l[6];
    logic [23:0]   ramp_r[6];

    i2s_rx_mod #(.BITWIDTH(BW), .SLOT_BITS(32)) dut (
        .ctl_clk    (ctl_clk),
        .ctl_rst    (ctl_rst),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_rx     (i2s_rx),
        .wave_out_l (wave_out_l),
        .wave_out_r (wave_out_r),
        .wave_valid (wave_valid),
        .frame_err  (frame_err)
    );

    // 100 MHz control clock
    initial ctl_clk = 1'b0;
    always #5 ctl_clk = ~ctl_clk;

    // Compare one value and log a failure line on mismatch
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pop the scoreboard on every valid strobe
    always @(negedge ctl_clk) begin
        logic [47:0] e;
        if (wave_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse actual l=%h r=%h required none", wave_out_l, wave_out_r);
            end else begin
                e = exp_q.pop_front();
                check_output("pair_l", 32'(wave_out_l), 32'(e[47:24]));
                check_output("pair_r", 32'(wave_out_r), 32'(e[23:0]));
            end
            check_output("valid_width", 32'(prev_valid), 32'd0);
        end
        prev_valid = wave_valid;
    end

    // One BCLK period: data and LRCK change while BCLK is low
    task automatic send_bit(input logic lr, input logic b);
        i2s_bclk = 1'b0;
        i2s_lrck = lr;
        i2s_rx   = b;
        repeat (half) @(negedge ctl_clk);
        i2s_bclk = 1'b1;
        repeat (half) @(negedge ctl_clk);
    endtask

    // One-cycle reset pulse mid-stream; outputs must clear immediately
    task automatic pulse_reset_check();
        @(negedge ctl_clk);
        ctl_rst = 1'b0;
        #1;
        check_output("rst_async_l", 32'(wave_out_l), 32'd0);
        check_output("rst_async_r", 32'(wave_out_r), 32'd0);
        check_output("rst_async_valid", 32'(wave_valid), 32'd0);
        check_output("rst_async_err", 32'(frame_err), 32'd0);
        @(negedge ctl_clk);
        ctl_rst = 1'b1;
    endtask

    // One I2S slot: the first bit is the previous slot's LSB (one-bit delay)
    task automatic send_slot(input logic lr, input int nbits, input logic [31:0] data,
                             input int rst_at, input int err_exp);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            if (i == 0) b = pending;
            else        b = data[nbits - i];
            if (i == rst_at) pulse_reset_check();
            send_bit(lr, b);
            if (i == 0 && err_exp >= 0) check_output("frame_err_at_change", 32'(frame_err), 32'(err_exp));
        end
        pending = data[0];
    endtask

    // Full reset with BCLK low and LRCK at the given level
    task automatic apply_reset(input logic lr);
        @(negedge ctl_clk);
        i2s_bclk = 1'b0;
        i2s_lrck = lr;
        i2s_rx   = 1'b0;
        pending  = 1'b0;
        ctl_rst  = 1'b0;
        repeat (4) @(negedge ctl_clk);
        ctl_rst = 1'b1;
        repeat (4) @(negedge ctl_clk);
    endtask

    // Start the next left slot so the last right slot closes, then drain
    task automatic finish_test(input string name);
        send_slot(1'b0, 3, 32'h0, -1, -1);
        repeat (20) @(negedge ctl_clk);
        check_output({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        checks     = 0;
        errors     = 0;
        half       = 8;
        prev_valid = 1'b0;
        pending    = 1'b0;
        ctl_rst    = 1'b0;
        i2s_bclk   = 1'b0;
        i2s_lrck   = 1'b0;
        i2s_rx     = 1'b0;

        ramp_l = '{24'h000100, 24'h000200, 24'h000300, 24'h000400, 24'h7FFFFF, 24'h800000};
        ramp_r = '{24'hFFFF00, 24'hFFFE00, 24'hFFFD00, 24'hFFFC00, 24'h800001, 24'h7FFFFE};

        // Reset state
        repeat (3) @(negedge ctl_clk);
        check_output("reset_l", 32'(wave_out_l), 32'd0);
        check_output("reset_r", 32'(wave_out_r), 32'd0);
        check_output("reset_valid", 32'(wave_valid), 32'd0);
        check_output("reset_err", 32'(frame_err), 32'd0);

        // Basic 32-bit frame; low byte of each slot lies beyond the word and is dropped
        $display("[TB] basic 32-bit frame");
        apply_reset(1'b0);
        send_slot(1'b1, 32, 32'hDEADBEEF, -1, -1);
        exp_q.push_back({24'h123456, 24'hABCDEF});
        send_slot(1'b0, 32, 32'h123456AB, -1, -1);
        send_slot(1'b1, 32, 32'hABCDEF5C, -1, -1);
        finish_test("basic");
        check_output("basic_err", 32'(frame_err), 32'd0);

        // Back-to-back ramp frames including extreme values
        $display("[TB] ramp frames");
        apply_reset(1'b0);
        send_slot(1'b1, 32, 32'h0, -1, -1);
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back({ramp_l[k], ramp_r[k]});
            send_slot(1'b0, 32, {ramp_l[k], 8'hC3}, -1, -1);
            send_slot(1'b1, 32, {ramp_r[k], 8'h3C}, -1, -1);
        end
        finish_test("ramp");

        // Reset released with LRCK high mid right slot: that slot is discarded
        $display("[TB] reset release mid right slot");
        @(negedge ctl_clk);
        i2s_lrck = 1'b1;
        pending  = 1'b0;
        ctl_rst  = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, i[0]);
        ctl_rst = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(1'b1, ~i[0]);
        exp_q.push_back({24'h55AA33, 24'hCC0F0F});
        send_slot(1'b0, 32, 32'h55AA3300, -1, -1);
        send_slot(1'b1, 32, 32'hCC0F0F77, -1, -1);
        finish_test("mid_right");

        // 16-bit slots with a slower BCLK: words come out left-justified
        $display("[TB] 16-bit slots");
        half = 16;
        apply_reset(1'b0);
        send_slot(1'b1, 16, 32'h00001234, -1, -1);
        exp_q.push_back({24'hA5A500, 24'h0F0F00});
        send_slot(1'b0, 16, 32'h0000A5A5, -1, -1);
        send_slot(1'b1, 16, 32'h00000F0F, -1, -1);
        finish_test("short");
        check_output("short_err", 32'(frame_err), 32'(SLOT_CHECK));
        half = 8;

        // One-cycle reset in the middle of a left slot
        $display("[TB] reset mid left slot");
        apply_reset(1'b0);
        send_slot(1'b1, 32, 32'h0, -1, -1);
        exp_q.push_back({24'h13579B, 24'h2468AC});
        send_slot(1'b0, 32, 32'h13579B00, -1, -1);
        send_slot(1'b1, 32, 32'h2468AC00, -1, -1);
        send_slot(1'b0, 32, 32'h11111100, 12, -1);
        check_output("pre_rerun_l", 32'(wave_out_l), 32'd0);
        send_slot(1'b1, 32, 32'h22222200, -1, -1);
        exp_q.push_back({24'hFEDCBA, 24'h012345});
        send_slot(1'b0, 32, 32'hFEDCBA00, -1, -1);
        send_slot(1'b1, 32, 32'h01234500, -1, -1);
        finish_test("mid_left");

        // One 31-bit left slot among 32-bit slots, then ten good frames
        $display("[TB] slot length error");
        apply_reset(1'b0);
        send_slot(1'b1, 32, 32'h0, -1, -1);
        exp_q.push_back({24'h0A0B0C, 24'h0D0E0F});
        send_slot(1'b0, 32, 32'h0A0B0C00, -1, -1);
        send_slot(1'b1, 32, 32'h0D0E0F00, -1, -1);
        check_output("err_before_bad", 32'(frame_err), 32'd0);
        exp_q.push_back({24'h765432, 24'h89ABCD});
        send_slot(1'b0, 31, 32'h3B2A1911, -1, -1);
        send_slot(1'b1, 32, 32'h89ABCD00, -1, SLOT_CHECK);
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back({24'(k * 3 + 1), 24'(k * 3 + 2)});
            send_slot(1'b0, 32, {24'(k * 3 + 1), 8'h00}, -1, -1);
            send_slot(1'b1, 32, {24'(k * 3 + 2), 8'h00}, -1, -1);
            check_output("err_sticky", 32'(frame_err), 32'(SLOT_CHECK));
        end
        finish_test("slot_err");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
